// File: rtl/adder_arb_pkg.sv
// Shared defaults, state encoding and helpers for the arbitrated adder.
package adder_arb_pkg;

    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ADD  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        ADD  = ST_ADD,
        DONE = ST_DONE
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   index
);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!valid && req[IW'(cand)]) begin
                valid = 1'b1;
                index = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered adder between NREQ requesters.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      a_i,
    input  logic [NREQ*WIDTH-1:0]      b_i,
    output logic [NREQ-1:0]            gnt,
    output logic                       busy,
    output logic                       done,
    output logic [idx_width(NREQ)-1:0] done_id,
    output logic [WIDTH-1:0]           res,
    output logic                       ovf
);

    localparam int unsigned IW = idx_width(NREQ);

    state_t            state;
    state_t            state_n;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     winner;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;
    logic [WIDTH:0]    sum_c;
    logic [WIDTH-1:0]  a_arr [NREQ];
    logic [WIDTH-1:0]  b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = a_i[i*WIDTH +: WIDTH];
        assign b_arr[i] = b_i[i*WIDTH +: WIDTH];
    end

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_picker (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign sum_c = {1'b0, op_a} + {1'b0, op_b};

    // Next-state logic; only IDLE waits on a request.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (pick_valid) state_n = LOAD;
            LOAD:    state_n = ADD;
            ADD:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            winner  <= '0;
            gnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            res     <= '0;
            ovf     <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            gnt   <= '0;
            done  <= 1'b0;
            // Winner and pointer are frozen on LOAD entry; gnt is high during LOAD.
            if (state == IDLE && pick_valid) begin
                winner <= pick_idx;
                ptr    <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
                gnt    <= NREQ'(1) << pick_idx;
            end
            if (state == LOAD) begin
                op_a <= a_arr[winner];
                op_b <= b_arr[winner];
            end
            if (state == ADD) begin
                res     <= sum_c[WIDTH-1:0];
                ovf     <= sum_c[WIDTH];
                done    <= 1'b1;
                done_id <= winner;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed and randomized checks of adder_arbiter against a round-robin adder model.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [1:0]  done_id;
    logic [15:0] res;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    logic [15:0] op_a [4];
    logic [15:0] op_b [4];
    int          mptr;
    logic [15:0] last_res;
    logic        last_ovf;
    logic [1:0]  last_id;

    adder_arbiter #(.NREQ(4), .WIDTH(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_i     (a_i),
        .b_i     (b_i),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .res     (res),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_ops();
        for (int i = 0; i < 4; i++) begin
            a_i[i*16 +: 16] = op_a[i];
            b_i[i*16 +: 16] = op_b[i];
        end
    endtask

    // Model: first requester at or after mptr, wrapping.
    function automatic int model_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_gnt"},  32'(gnt),  32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check_idle_outputs(tag);
        chk({tag, "_id"},  32'(done_id), 32'd0);
        chk({tag, "_res"}, 32'(res),     32'd0);
        chk({tag, "_ovf"}, 32'(ovf),     32'd0);
    endtask

    // One transaction from IDLE; perturb drops the winner's req and flips its A during ADD.
    task automatic run_txn(input string tag, input logic [3:0] r, input bit perturb);
        int w;
        int s;
        req = r;
        pack_ops();
        w = model_pick(r, mptr);
        s = int'(op_a[w]) + int'(op_b[w]);
        mptr = (w + 1) % 4;
        step();
        chk({tag, "_gnt"},  32'(gnt),  32'(4'b0001 << w));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_done_early"}, 32'(done), 32'd0);
        step();
        chk({tag, "_gnt_pulse"}, 32'(gnt), 32'd0);
        if (perturb) begin
            req = r & ~(4'b0001 << w);
            op_a[w] = ~op_a[w];
            pack_ops();
        end
        step();
        chk({tag, "_done"}, 32'(done),    32'd1);
        chk({tag, "_id"},   32'(done_id), 32'(w));
        chk({tag, "_res"},  32'(res),     32'(s & 32'hFFFF));
        chk({tag, "_ovf"},  32'(ovf),     32'(s >> 16));
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_end"},   32'(busy), 32'd0);
        chk({tag, "_res_hold"},   32'(res),  32'(s & 32'hFFFF));
        last_res = res;
        last_ovf = ovf;
        last_id  = done_id;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        step();
        step();
        rst = 1'b0;
        mptr = 0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        a_i = '0;
        b_i = '0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        mptr = 0;

        // Reset state
        do_reset();
        check_zero("reset");

        // Single requester 0: 3 + 4
        op_a[0] = 16'h0003;
        op_b[0] = 16'h0004;
        run_txn("basic", 4'b0001, 1'b0);
        chk("basic_res_const", 32'(last_res), 32'h7);
        req = '0;

        // All requesters held: order 0,1,2,3,0 after reset
        do_reset();
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) begin
                op_a[i] = 16'($urandom);
                op_b[i] = 16'($urandom);
            end
            run_txn("rr_all", 4'b1111, 1'b0);
            chk("rr_order", 32'(last_id), 32'(n % 4));
        end
        req = '0;
        step();

        // Overflow from requester 3, then pointer wrap grants requester 0
        op_a[3] = 16'hFFFF;
        op_b[3] = 16'h0001;
        run_txn("ovf", 4'b1000, 1'b0);
        chk("ovf_res_const", 32'(last_res), 32'h0);
        chk("ovf_bit_const", 32'(last_ovf), 32'h1);
        chk("ovf_id_const",  32'(last_id),  32'h3);
        op_a[0] = 16'h1234;
        op_b[0] = 16'h1111;
        run_txn("wrap", 4'b1001, 1'b0);
        chk("wrap_id", 32'(last_id), 32'h0);
        req = '0;

        // Operands changed and req dropped after capture
        op_a[1] = 16'h00AA;
        op_b[1] = 16'h0055;
        run_txn("capture", 4'b0010, 1'b1);
        chk("capture_res_const", 32'(last_res), 32'h00FF);
        req = '0;

        // Reset during ADD aborts the transaction
        op_a[2] = 16'h0100;
        op_b[2] = 16'h0200;
        req = 4'b0100;
        pack_ops();
        step();
        chk("abort_gnt", 32'(gnt), 32'h4);
        step();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        mptr = 0;
        check_zero("abort");
        step();
        chk("abort_no_done", 32'(done), 32'd0);
        op_a[1] = 16'h0010;
        op_b[1] = 16'h0020;
        op_a[3] = 16'h0030;
        op_b[3] = 16'h0040;
        run_txn("after_abort", 4'b1010, 1'b0);
        chk("after_abort_id", 32'(last_id), 32'h1);
        req = '0;
        step();

        // Idle for 20 cycles
        for (int c = 0; c < 20; c++) begin
            step();
            check_idle_outputs("idle");
        end

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 4; i++) begin
                op_a[i] = 16'($urandom);
                op_b[i] = 16'($urandom);
            end
            run_txn("rand", 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
            req = '0;
            if ($urandom_range(0, 1) == 1) begin
                step();
                check_idle_outputs("rand_gap");
                chk("rand_hold", 32'(res), 32'(last_res));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the adder.
REQ-002 Parameter WIDTH, default 16, operand and result width.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester level request; bit i high = requester i wants one addition.
REQ-006 a_i  input  NREQ*WIDTH  packed operand A; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-007 b_i  input  NREQ*WIDTH  packed operand B, same packing as a_i.
REQ-008 gnt  output  NREQ  one-hot grant pulse; marks the cycle operands of the winner are sampled.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 done  output  1  one-cycle pulse; res, ovf, done_id are valid in this cycle.
REQ-011 done_id  output  clog2(NREQ)  index of the requester whose result is presented.
REQ-012 res  output  WIDTH  sum, modulo 2^WIDTH.
REQ-013 ovf  output  1  unsigned carry out of the sum.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, ADD, DONE; transitions IDLE->LOAD when req != 0, LOAD->ADD, ADD->DONE, DONE->IDLE, all unconditional except IDLE.
REQ-015 In IDLE the arbiter SHALL pick the winner by round-robin: first set req bit at or above pointer ptr, wrapping NREQ-1 -> 0.
REQ-016 Winner index SHALL be registered on the IDLE->LOAD edge; req changes after that edge do not alter the current transaction.
REQ-017 In LOAD gnt[winner] SHALL be high for exactly one cycle and the winner's a_i/b_i slices SHALL be captured into internal registers that cycle.
REQ-018 In ADD the registered operands SHALL be summed at WIDTH+1 bits; low WIDTH bits -> res register, MSB -> ovf register.
REQ-019 In DONE done SHALL be high for exactly one cycle with done_id = winner; res/ovf/done_id SHALL hold their values until the next DONE.
REQ-020 ptr SHALL update to (winner+1) mod NREQ on LOAD entry.
REQ-021 Latency: req seen in IDLE at edge t -> gnt during cycle t+1 -> done during cycle t+3; one transaction per 4 cycles maximum.
REQ-022 Requester SHALL drop req in the cycle after gnt if it has no further work; a still-high req is re-arbitrated normally (no starvation of others, guaranteed by REQ-020).
REQ-023 req == 0 in IDLE: FSM SHALL stay in IDLE, busy low, no gnt.
REQ-024 Only one gnt bit and at most one done pulse SHALL be active in any cycle.

Reset
REQ-025 rst high at a clock edge SHALL force state IDLE, ptr 0, gnt 0, busy 0, done 0, done_id 0, res 0, ovf 0, operand registers 0.
REQ-026 rst asserted mid-transaction SHALL abort it; no done pulse for the aborted request, arbitration restarts with requester 0 highest priority.

Structure
REQ-027 State encoding localparams and default NREQ/WIDTH SHALL live in the shared package adder_arb_pkg.
REQ-028 Round-robin selection SHALL be a separate combinational sub-module rr_picker (inputs req, ptr; outputs valid, index).
REQ-029 Adder SHALL be inline in adder_arbiter; no other sub-modules.

Verification
REQ-030 Reset then req=0001, a0=0x0003, b0=0x0004 -> gnt=0001 one cycle after, done 3 cycles after req sample, res=0x0007, ovf=0, done_id=0.
REQ-031 req=1111 held continuously, distinct operands -> grant order 0,1,2,3,0 with done_id matching, each result correct.
REQ-032 req[3] only, a3=0xFFFF, b3=0x0001 -> res=0x0000, ovf=1, done_id=3; next request from 0 after ptr wrap granted.
REQ-033 req[1] dropped and a1 changed during ADD -> result uses operands captured in LOAD, done still issued.
REQ-034 rst asserted in ADD -> no done, outputs zero next cycle; subsequent req=1010 grants requester 1 first.
REQ-035 req=0 for 20 cycles -> busy, gnt, done remain low throughout.
